// File: rtl/gpio_host_driver_pkg.sv
// Shared definitions for the GPIO host driver: command op-codes, GPIO word
// field positions and the command sequencer state encoding.
package gpio_host_driver_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] Kernel_load        = 3'd0;
  localparam logic [OP_W-1:0] ImgSize_load       = 3'd1;
  localparam logic [OP_W-1:0] Img_load           = 3'd2;
  localparam logic [OP_W-1:0] Data_request       = 3'd3;
  localparam logic [OP_W-1:0] LoadFinish_goToRun = 3'd4;

  localparam int RST_BIT   = 0;
  localparam int DATA_LSB  = 1;
  localparam int VALID_BIT = 28;
  localparam int CTRL_LSB  = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= LoadFinish_goToRun;
  endfunction

endpackage

// File: rtl/gpio_host_driver.sv
// Serialises valid/ready commands onto the 32-bit GPIO command word of the
// convolution subsystem and samples the returned result for data requests.
module gpio_host_driver
  import gpio_host_driver_pkg::*;
#(
  parameter int GPIO_D      = 32,
  parameter int DATA_LEN    = 24,
  parameter int BITS_DATA   = 13,
  parameter int HOLD_CYCLES = 4,
  parameter int RD_LATENCY  = 6
) (
  input  logic                 i_CLK,
  input  logic                 i_rst,
  input  logic                 i_dut_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [OP_W-1:0]      i_cmd_op,
  input  logic [DATA_LEN-1:0]  i_cmd_data,
  output logic [GPIO_D-1:0]    o_gpio_data,
  input  logic [GPIO_D-1:0]    i_gpio_data,
  output logic                 o_rsp_valid,
  output logic [BITS_DATA-1:0] o_rsp_data,
  output logic                 o_err,
  output logic                 o_busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > RD_LATENCY) ? HOLD_CYCLES : RD_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OP_W-1:0]      ctrl_q, ctrl_d;
  logic [DATA_LEN-1:0]  data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 dut_rst_q;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BITS_DATA-1:0] rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 gpio_in_unused;

  assign gpio_in_unused = ^i_gpio_data[GPIO_D-1:BITS_DATA];

  assign accept = i_cmd_valid && (state_q == ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_legal(i_cmd_op)) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            ctrl_d  = i_cmd_op;
            data_d  = i_cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = HOLD_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == '0) begin
          if (ctrl_q == Data_request) begin
            state_d = ST_WAIT_RD;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          rsp_data_d = i_gpio_data[BITS_DATA-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Strobe and response flags are registered from the next state so they
    // line up with the state they belong to rather than lagging it.
    valid_d     = (state_d == ST_STROBE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      dut_rst_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      dut_rst_q   <= i_dut_rst;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    o_gpio_data                       = '0;
    o_gpio_data[RST_BIT]              = dut_rst_q;
    o_gpio_data[DATA_LSB +: DATA_LEN] = data_q;
    o_gpio_data[VALID_BIT]            = valid_q;
    o_gpio_data[CTRL_LSB +: OP_W]     = ctrl_q;
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_gpio_host_driver.sv
// Self-checking bench for gpio_host_driver: directed scenarios followed by
// randomized commands, compared against a cycle-count reference model.
module tb_gpio_host_driver;

  localparam int GPIO_D    = 32;
  localparam int DATA_LEN  = 24;
  localparam int BITS_DATA = 13;
  localparam int HOLD      = 4;
  localparam int RDL       = 6;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_dut_rst;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [2:0]           i_cmd_op;
  logic [DATA_LEN-1:0]  i_cmd_data;
  logic [GPIO_D-1:0]    o_gpio_data;
  logic [GPIO_D-1:0]    i_gpio_data;
  logic                 o_rsp_valid;
  logic [BITS_DATA-1:0] o_rsp_data;
  logic                 o_err;
  logic                 o_busy;

  int checks = 0;
  int errors = 0;

  // Reference state: last command fields seen on the word, last response,
  // and the dut-reset level presented before the most recent edge.
  logic                 cur_rst;
  bit                   rand_rst;
  logic [2:0]           exp_ctrl;
  logic [DATA_LEN-1:0]  exp_data;
  logic [BITS_DATA-1:0] exp_rsp;

  always #5 clk = ~clk;

  gpio_host_driver #(
    .GPIO_D(GPIO_D), .DATA_LEN(DATA_LEN), .BITS_DATA(BITS_DATA),
    .HOLD_CYCLES(HOLD), .RD_LATENCY(RDL)
  ) dut (
    .i_CLK(clk), .i_rst(i_rst), .i_dut_rst(i_dut_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .o_gpio_data(o_gpio_data), .i_gpio_data(i_gpio_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_err(o_err), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic rst, input logic [2:0] ctrl,
                                             input logic [DATA_LEN-1:0] data, input logic vld);
    return (32'(ctrl) << 29) | (32'(vld) << 28) | (32'(data) << 1) | 32'(rst);
  endfunction

  // One cycle: sample at the falling edge and compare every output.
  task automatic step(input string tag, input logic vld, input logic rdy,
                      input logic rv, input logic er);
    @(negedge clk);
    check({tag, " word"}, o_gpio_data, model_word(cur_rst, exp_ctrl, exp_data, vld));
    check({tag, " ready"}, o_cmd_ready, rdy);
    check({tag, " busy"}, o_busy, !rdy);
    check({tag, " rsp_valid"}, o_rsp_valid, rv);
    check({tag, " rsp_data"}, o_rsp_data, exp_rsp);
    check({tag, " err"}, o_err, er);
    if (rand_rst) begin
      cur_rst   = 1'($urandom_range(0, 1));
      i_dut_rst = cur_rst;
    end
  endtask

  // Offer one command while idle; cycle n counts edges after the accept edge.
  task automatic run_cmd(input logic [2:0] op, input logic [DATA_LEN-1:0] data,
                         input logic [GPIO_D-1:0] gin);
    int total;
    i_gpio_data = gin;
    i_cmd_op    = op;
    i_cmd_data  = data;
    i_cmd_valid = 1'b1;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    if (op > 3'd4) begin
      step($sformatf("op%0d err", op), 1'b0, 1'b1, 1'b0, 1'b1);
      step($sformatf("op%0d post", op), 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      exp_ctrl = op;
      exp_data = data;
      total = (op == 3'd3) ? 2 * HOLD + RDL + 3 : 2 * HOLD + 2;
      for (int n = 1; n <= total; n++) begin
        if (op == 3'd3 && n == total - 1) exp_rsp = gin[BITS_DATA-1:0];
        step($sformatf("op%0d n%0d", op, n), (n >= 2 && n <= HOLD + 1),
             (n == total), (op == 3'd3 && n == total - 1), 1'b0);
      end
    end
  endtask

  initial begin
    int accepts, strobes, low_run, gap;
    bit drop, prev_v, v;
    logic [2:0] rop;

    i_rst = 1'b1; i_dut_rst = 1'b0; i_cmd_valid = 1'b0;
    i_cmd_op = '0; i_cmd_data = '0; i_gpio_data = '0;
    cur_rst = 1'b0; rand_rst = 1'b0;
    exp_ctrl = '0; exp_data = '0; exp_rsp = '0;

    repeat (3) @(negedge clk);
    check("reset word", o_gpio_data, 32'h0000_0001);
    check("reset ready", o_cmd_ready, 1'b1);
    check("reset busy", o_busy, 1'b0);
    check("reset rsp_valid", o_rsp_valid, 1'b0);
    check("reset rsp_data", o_rsp_data, '0);
    check("reset err", o_err, 1'b0);
    i_rst = 1'b0;
    step("idle", 1'b0, 1'b1, 1'b0, 1'b0);

    run_cmd(3'd0, 24'h0A0B0C, '0);
    check("kernel final word", o_gpio_data, 32'h0014_1618);

    run_cmd(3'd3, 24'($urandom), 32'h0000_1ABC);
    check("data request rsp_data", o_rsp_data, 13'h1ABC);

    run_cmd(3'd6, 24'($urandom), 32'($urandom));

    // Reset while the image-load strobe is high.
    i_cmd_op = 3'd2; i_cmd_data = 24'($urandom); i_cmd_valid = 1'b1;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    exp_ctrl = 3'd2; exp_data = i_cmd_data;
    step("img n1", 1'b0, 1'b0, 1'b0, 1'b0);
    step("img n2", 1'b1, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    @(negedge clk);
    check("midrst word", o_gpio_data, 32'h0000_0001);
    check("midrst ready", o_cmd_ready, 1'b1);
    check("midrst busy", o_busy, 1'b0);
    check("midrst rsp_valid", o_rsp_valid, 1'b0);
    i_rst = 1'b0;
    exp_ctrl = '0; exp_data = '0; exp_rsp = '0;
    for (int k = 0; k < 20; k++) step("post-reset idle", 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmd(3'd4, 24'($urandom), '0);

    // Offerer holds valid high across two image-size loads.
    i_cmd_op = 3'd1; i_cmd_data = 24'($urandom); i_cmd_valid = 1'b1;
    accepts = 0; strobes = 0; low_run = 0; gap = -1; drop = 1'b0; prev_v = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (i_cmd_valid && o_cmd_ready) begin
        accepts++;
        if (accepts == 2) drop = 1'b1;
      end
      @(posedge clk);
      #1 if (drop) i_cmd_valid = 1'b0;
      @(negedge clk);
      v = o_gpio_data[28];
      if (v && !prev_v) begin
        strobes++;
        if (strobes == 2) gap = low_run;
      end
      if (!v) low_run++; else low_run = 0;
      prev_v = v;
    end
    check("b2b accepts", 64'(accepts), 64'd2);
    check("b2b strobes", 64'(strobes), 64'd2);
    check("b2b gap ok", 64'(gap >= HOLD), 64'd1);
    exp_ctrl = 3'd1; exp_data = i_cmd_data;
    step("b2b done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized commands with a toggling DUT-reset request.
    rand_rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) rop = 3'($urandom_range(5, 7));
      else rop = 3'($urandom_range(0, 4));
      run_cmd(rop, 24'($urandom), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
